ram2_ctrl: RTL
==============

Name: ram2_ctrl

Overview:
Initiator-side controller that drives the board's RAM2 SRAM chip on behalf of the CPU pipeline.
It arbitrates between instruction fetch (IF stage) and data access (MEM stage), and sequences the SRAM strobes with configurable timing.
It returns fetched instructions and read data to the pipeline, and raises a stall request while an access is outstanding.
It sits between the core and the top-level tri-state pad logic for the RAM2 data bus.

Parameters:
RD_CYCLES, 2, cycles with OE active before read data is sampled (>=1)
WR_CYCLES, 2, width of the WE low pulse in cycles (>=1)
ADDR_HI, 2'b00, constant upper bits [17:16] of the SRAM address

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset
if_req  in  1  instruction fetch request
if_addr  in  16  fetch address (pc)
inst_o  out  16  fetched instruction
inst_valid  out  1  one-cycle pulse: inst_o is valid
mem_re  in  1  data read request
mem_we  in  1  data write request
mem_addr_i  in  16  data address
mem_data_i  in  16  write data
mem_data_o  out  16  read data
mem_done  out  1  one-cycle pulse: data access complete
stall_req  out  1  stall request to pipeline control
ram2_addr  out  18  SRAM address
ram2_data_o  out  16  SRAM write data (to pad)
ram2_data_i  in  16  SRAM read data (from pad)
ram2_data_oe  out  1  1 = top drives the pad with ram2_data_o
ram2_en_n  out  1  SRAM chip enable, active-low
ram2_oe_n  out  1  SRAM output enable, active-low
ram2_we_n  out  1  SRAM write enable, active-low

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-low: rst==0 sampled at a clk rising edge.
- Reset values: state=IDLE; ram2_en_n=1, ram2_oe_n=1, ram2_we_n=1; ram2_data_oe=0; ram2_addr=0; ram2_data_o=0; inst_o=16'h0800 (NOP); inst_valid=0; mem_data_o=0; mem_done=0.
- All outputs are registered except stall_req.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE selects one request per edge. Priority: mem_we > mem_re > if_req.
  - mem_we and mem_re both high: treated as a write; the read is ignored.
- Read (data or fetch) accepted at edge k:
  - IDLE->RD. ram2_addr={ADDR_HI, addr}; en_n=0, oe_n=0; counter=RD_CYCLES-1.
  - RD: counter decrements each edge.
  - At the edge where counter==0: ram2_data_i is latched into mem_data_o (data read) or inst_o (fetch); en_n=1, oe_n=1; ->DONE.
  - Latch occurs at edge k+RD_CYCLES.
- Write accepted at edge k:
  - WR_SETUP for 1 cycle: addr driven, ram2_data_o=mem_data_i, data_oe=1, en_n=0, we_n=1.
  - WR_PULSE for WR_CYCLES cycles: we_n=0.
  - WR_HOLD for 1 cycle: we_n=1; data_oe and en_n remain asserted.
  - Then ->DONE: data_oe=0, en_n=1.
  - Address and data are held constant throughout WR_*.
- DONE lasts exactly 1 cycle:
  - mem_done=1 (data access) or inst_valid=1 (fetch).
  - No new request is accepted in DONE; returns to IDLE. This prevents re-launching a request still held by the pipeline.
- ram2_we_n and ram2_oe_n are never both 0.
- stall_req (combinational) = ((mem_re|mem_we) & ~mem_done) | (if_req & ~inst_valid).
- inst_o and mem_data_o hold their last values until overwritten.
- Reset mid-operation: at the reset edge all strobes return inactive, data_oe=0, state=IDLE. No done or valid pulse; a partial write is aborted.
- Requests deasserted mid-access are ignored: the access completes and pulses done. Inputs are sampled only in IDLE.

Test Plan:
- Hold rst=0 for 2 cycles, then release -> all outputs equal the reset values; en_n/oe_n/we_n=1, inst_o=16'h0800, stall_req=0 with no requests.
- if_req=1, if_addr=16'h0002; SRAM model returns 16'h69BF; RD_CYCLES=2 -> ram2_addr=18'h00002 and oe_n=0 for 2 cycles; inst_o=16'h69BF; inst_valid pulses 1 cycle; stall_req=1 until that pulse.
- mem_re and if_req asserted in the same cycle; mem_addr_i=16'h0004 -> data read served first, mem_data_o = SRAM[4] with mem_done pulse; fetch starts after DONE and inst_valid pulses later.
- mem_we=1, addr=16'h0010, data=16'hBEEF, WR_CYCLES=2 -> sequence SETUP(we_n=1) / 2 cycles we_n=0 / HOLD(we_n=1); data_oe=1 across all 4 cycles; SRAM[0x10]=16'hBEEF; mem_done pulse; subsequent read of 0x10 returns 16'hBEEF.
- rst=0 during the first WR_PULSE cycle -> next edge: we_n=1, data_oe=0, state IDLE, no mem_done pulse.
- Request held high across DONE -> exactly one idle cycle between accesses; no duplicate access issued in the DONE cycle.

Source files
------------

// File: rtl/ram2_ctrl.sv
// RAM2 SRAM initiator: arbitrates IF fetch and MEM data accesses,
// sequences EN/OE/WE strobes and returns results to the pipeline.
module ram2_ctrl #(
   parameter int unsigned RD_CYCLES = 2,
   parameter int unsigned WR_CYCLES = 2,
   parameter logic [1:0]  ADDR_HI   = 2'b00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [15:0] if_addr,
   output logic [15:0] inst_o,
   output logic        inst_valid,
   input  logic        mem_re,
   input  logic        mem_we,
   input  logic [15:0] mem_addr_i,
   input  logic [15:0] mem_data_i,
   output logic [15:0] mem_data_o,
   output logic        mem_done,
   output logic        stall_req,
   output logic [17:0] ram2_addr,
   output logic [15:0] ram2_data_o,
   input  logic [15:0] ram2_data_i,
   output logic        ram2_data_oe,
   output logic        ram2_en_n,
   output logic        ram2_oe_n,
   output logic        ram2_we_n
);

   localparam int CW = 8;
   localparam logic [CW-1:0] RD_LOAD = CW'(RD_CYCLES - 1);
   localparam logic [CW-1:0] WR_LOAD = CW'(WR_CYCLES - 1);
   localparam logic [15:0]   NOP     = 16'h0800;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WR_SETUP,
      WR_PULSE,
      WR_HOLD,
      DONE
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          fetch_q, fetch_d;
   logic [17:0]   addr_q, addr_d;
   logic [15:0]   wdata_q, wdata_d;
   logic          doe_q, doe_d;
   logic          en_n_q, en_n_d;
   logic          oe_n_q, oe_n_d;
   logic          we_n_q, we_n_d;
   logic [15:0]   inst_q, inst_d;
   logic          ivld_q, ivld_d;
   logic [15:0]   rdata_q, rdata_d;
   logic          done_q, done_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fetch_d = fetch_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      doe_d   = doe_q;
      en_n_d  = en_n_q;
      oe_n_d  = oe_n_q;
      we_n_d  = we_n_q;
      inst_d  = inst_q;
      ivld_d  = 1'b0;
      rdata_d = rdata_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            // write wins over a simultaneous read; fetch goes last
            if (mem_we) begin
               fetch_d = 1'b0;
               addr_d  = {ADDR_HI, mem_addr_i};
               wdata_d = mem_data_i;
               doe_d   = 1'b1;
               en_n_d  = 1'b0;
               we_n_d  = 1'b1;
               state_d = WR_SETUP;
            end else if (mem_re || if_req) begin
               fetch_d = ~mem_re;
               addr_d  = mem_re ? {ADDR_HI, mem_addr_i}
                                : {ADDR_HI, if_addr};
               en_n_d  = 1'b0;
               oe_n_d  = 1'b0;
               cnt_d   = RD_LOAD;
               state_d = RD;
            end
         end
         RD: begin
            if (cnt_q == '0) begin
               if (fetch_q) inst_d = ram2_data_i;
               else         rdata_d = ram2_data_i;
               ivld_d  = fetch_q;
               done_d  = ~fetch_q;
               en_n_d  = 1'b1;
               oe_n_d  = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         WR_SETUP: begin
            we_n_d  = 1'b0;
            cnt_d   = WR_LOAD;
            state_d = WR_PULSE;
         end
         WR_PULSE: begin
            if (cnt_q == '0) begin
               we_n_d  = 1'b1;
               state_d = WR_HOLD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         WR_HOLD: begin
            doe_d   = 1'b0;
            en_n_d  = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         fetch_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         doe_q   <= 1'b0;
         en_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
         inst_q  <= NOP;
         ivld_q  <= 1'b0;
         rdata_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fetch_q <= fetch_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         doe_q   <= doe_d;
         en_n_q  <= en_n_d;
         oe_n_q  <= oe_n_d;
         we_n_q  <= we_n_d;
         inst_q  <= inst_d;
         ivld_q  <= ivld_d;
         rdata_q <= rdata_d;
         done_q  <= done_d;
      end
   end

   assign ram2_addr    = addr_q;
   assign ram2_data_o  = wdata_q;
   assign ram2_data_oe = doe_q;
   assign ram2_en_n    = en_n_q;
   assign ram2_oe_n    = oe_n_q;
   assign ram2_we_n    = we_n_q;
   assign inst_o       = inst_q;
   assign inst_valid   = ivld_q;
   assign mem_data_o   = rdata_q;
   assign mem_done     = done_q;

   assign stall_req = ((mem_re | mem_we) & ~done_q)
                    | (if_req & ~ivld_q);

endmodule
